a51_pixel_cipher: RTL and testbench

- Downstream consumer of the A5/1 keystream generator in the image-encryption datapath.
- Accepts one keystream bit per cycle and packs 8 bits into a keystream byte.
- XORs each keystream byte with one incoming pixel byte and emits the encrypted pixel over a valid/ready stream.
- Counts pixels per image, pulses done after the last encrypted pixel leaves, and must be re-armed with start for the next image.

---
 rtl/a51_pkg.sv | 14 +
 rtl/a51_pixel_cipher_if.sv | 33 +++
 rtl/a51_pixel_cipher_ks_byte_packer.sv | 52 +++++
 rtl/a51_pixel_cipher.sv | 90 +++++++++
 tb/tb_a51_pixel_cipher.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/a51_pkg.sv
// Shared definitions for the A5/1 image-encryption datapath.
package a51_pkg;

  localparam int PIX_W          = 8;
  localparam int NUM_PIXELS_DEF = 65536;

  // Control FSM encoding shared by the cipher and the key-loader controller
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/a51_pixel_cipher_if.sv
// Control, keystream and pixel stream signals of the pixel cipher.
interface a51_pixel_cipher_if
  import a51_pkg::*;
#(
  parameter int DATA_W = PIX_W
) ();

  logic              start;
  logic              ks_bit;
  logic              ks_valid;
  logic              ks_ready;
  logic [DATA_W-1:0] pix_in_data;
  logic              pix_in_valid;
  logic              pix_in_ready;
  logic [DATA_W-1:0] pix_out_data;
  logic              pix_out_valid;
  logic              pix_out_ready;
  logic              busy;
  logic              done;

  // Driver side: keystream source, pixel source and pixel sink
  modport master (
    output start, ks_bit, ks_valid, pix_in_data, pix_in_valid, pix_out_ready,
    input  ks_ready, pix_in_ready, pix_out_data, pix_out_valid, busy, done
  );

  // Cipher side
  modport slave (
    input  start, ks_bit, ks_valid, pix_in_data, pix_in_valid, pix_out_ready,
    output ks_ready, pix_in_ready, pix_out_data, pix_out_valid, busy, done
  );

endinterface

// File: rtl/a51_pixel_cipher_ks_byte_packer.sv
// Packs the serial keystream MSB-first into one buffered byte.
module ks_byte_packer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,      // new image: restart byte alignment
  input  logic              en,       // keystream may be consumed (RUN)
  input  logic              ks_bit,
  input  logic              ks_valid,
  input  logic              consume,  // pixel handshake takes the byte
  output logic              ks_ready,
  output logic [DATA_W-1:0] ks_byte,
  output logic              byte_full
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] wr_idx;
  logic          ks_hs;

  // A full byte blocks the generator so no bit is ever dropped or reused
  assign ks_ready = en && !byte_full;
  assign ks_hs    = ks_valid && ks_ready;
  assign wr_idx   = LAST - bit_cnt;

  // Shift-in register, bit position and byte-full flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ks_byte   <= '0;
      bit_cnt   <= '0;
      byte_full <= 1'b0;
    end else if (clr) begin
      bit_cnt   <= '0;
      byte_full <= 1'b0;
    end else begin
      if (ks_hs) begin
        ks_byte[wr_idx] <= ks_bit;
        if (bit_cnt == LAST) begin
          bit_cnt   <= '0;
          byte_full <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + BW'(1);
        end
      end
      if (consume) byte_full <= 1'b0;
    end
  end

endmodule

// File: rtl/a51_pixel_cipher.sv
// XORs each plaintext pixel with one packed keystream byte; counts an image
// of NUM_PIXELS and pulses done once the last encrypted pixel has left.
module a51_pixel_cipher
  import a51_pkg::*;
#(
  parameter int DATA_W     = PIX_W,
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int CNT_W      = $clog2(NUM_PIXELS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  a51_pixel_cipher_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PIXELS - 1);

  state_t            state;
  logic [CNT_W-1:0]  pix_cnt;
  logic [DATA_W-1:0] ks_byte;
  logic              byte_full;
  logic              ks_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              in_ready;
  logic              in_hs;
  logic              out_hs;
  logic              arm;

  assign arm      = (state == ST_IDLE) && bus.start;
  // Output slot is free when empty or being drained this cycle
  assign in_ready = (state == ST_RUN) && byte_full && (!out_valid || bus.pix_out_ready);
  assign in_hs    = bus.pix_in_valid && in_ready;
  assign out_hs   = out_valid && bus.pix_out_ready;

  assign bus.ks_ready      = ks_ready;
  assign bus.pix_in_ready  = in_ready;
  assign bus.pix_out_data  = out_data;
  assign bus.pix_out_valid = out_valid;
  assign bus.busy          = (state == ST_RUN) || (state == ST_DRAIN);
  assign bus.done          = (state == ST_DONE);

  ks_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (arm),
    .en        (state == ST_RUN),
    .ks_bit    (bus.ks_bit),
    .ks_valid  (bus.ks_valid),
    .consume   (in_hs),
    .ks_ready  (ks_ready),
    .ks_byte   (ks_byte),
    .byte_full (byte_full)
  );

  // Image control: arm, stream, wait for last output, one-cycle done
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (bus.start) state <= ST_RUN;
        ST_RUN:   if (in_hs && (pix_cnt == CNT_LAST)) state <= ST_DRAIN;
        ST_DRAIN: if (!out_valid || out_hs) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Pixels accepted in the current image, saturating at the image size
  always_ff @(posedge clk) begin
    if (reset || arm) pix_cnt <= '0;
    else if (in_hs && (pix_cnt != CNT_MAX)) pix_cnt <= pix_cnt + CNT_W'(1);
  end

  // Output register: reload on input handshake, else empty on output handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (in_hs) begin
      out_data  <= bus.pix_in_data ^ ks_byte;
      out_valid <= 1'b1;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_a51_pixel_cipher.sv
// Directed self-checking bench for a51_pixel_cipher.
module tb_a51_pixel_cipher;
  import a51_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  a51_pixel_cipher_if #(.DATA_W(8)) b  ();
  a51_pixel_cipher_if #(.DATA_W(8)) b1 ();

  a51_pixel_cipher #(.DATA_W(8), .NUM_PIXELS(4)) u_dut (
    .clk(clk), .reset(reset), .bus(b.slave));
  a51_pixel_cipher #(.DATA_W(8), .NUM_PIXELS(1)) u_one (
    .clk(clk), .reset(reset), .bus(b1.slave));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b.start = 0; b.ks_bit = 0; b.ks_valid = 0; b.pix_in_data = 0;
    b.pix_in_valid = 0; b.pix_out_ready = 0;
    b1.start = 0; b1.ks_bit = 0; b1.ks_valid = 0; b1.pix_in_data = 0;
    b1.pix_in_valid = 0; b1.pix_out_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start();
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
  endtask

  task automatic feed_bit(input logic v);
    int n = 0;
    b.ks_valid = 1'b1;
    b.ks_bit   = v;
    #1;
    while (!b.ks_ready && n < 64) begin tick(); n++; end
    if (!b.ks_ready) begin
      tests++; fails++;
      $display("FAIL feed_bit_timeout got ks_ready=%b want 1", b.ks_ready);
    end
    tick();
    b.ks_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) feed_bit(v[i]);
  endtask

  task automatic send_pix(input logic [7:0] d);
    int n = 0;
    b.pix_in_valid = 1'b1;
    b.pix_in_data  = d;
    #1;
    while (!b.pix_in_ready && n < 64) begin tick(); n++; end
    if (!b.pix_in_ready) begin
      tests++; fails++;
      $display("FAIL send_pix_timeout got pix_in_ready=%b want 1", b.pix_in_ready);
    end
    tick();
    b.pix_in_valid = 1'b0;
  endtask

  // Reset clears every output and wins over a simultaneous start
  task automatic test_reset();
    logic [12:0] o;
    idle_inputs();
    reset = 1'b1;
    b.start = 1; b.ks_valid = 1; b.pix_in_valid = 1; b.pix_out_ready = 1;
    b1.start = 1; b1.ks_valid = 1;
    tick(); tick();
    o = {b.pix_out_data, b.pix_out_valid, b.busy, b.done, b.ks_ready, b.pix_in_ready};
    tests++;
    if (o !== 13'd0) begin fails++; $display("FAIL reset_outputs got %h want 0", o); end
    o = {b1.pix_out_data, b1.pix_out_valid, b1.busy, b1.done, b1.ks_ready, b1.pix_in_ready};
    tests++;
    if (o !== 13'd0) begin fails++; $display("FAIL reset_outputs_n1 got %h want 0", o); end
    idle_inputs();
    reset = 1'b0;
    tick();
    tests++;
    if (b.busy !== 1'b0 || b1.busy !== 1'b0) begin
      fails++; $display("FAIL reset_idle got busy=%b/%b want 0/0", b.busy, b1.busy);
    end
  endtask

  // NUM_PIXELS=1, all-ones keystream: 0x5A -> 0xA5, then done
  task automatic test_single_pixel();
    b1.ks_valid = 1; b1.ks_bit = 1;
    b1.start = 1;
    tick();
    b1.start = 0;
    repeat (8) tick();
    b1.pix_in_valid = 1; b1.pix_in_data = 8'h5A; b1.pix_out_ready = 1;
    #1;
    tests++;
    if (b1.pix_in_ready !== 1'b1) begin
      fails++; $display("FAIL single_in_ready got %b want 1", b1.pix_in_ready);
    end
    tick();
    b1.pix_in_valid = 0;
    tests++;
    if (b1.pix_out_valid !== 1'b1 || b1.pix_out_data !== 8'hA5 || b1.done !== 1'b0) begin
      fails++; $display("FAIL single_out got v=%b d=%h done=%b want v=1 d=a5 done=0",
                        b1.pix_out_valid, b1.pix_out_data, b1.done);
    end
    tick();
    tests++;
    if (b1.done !== 1'b1 || b1.busy !== 1'b0) begin
      fails++; $display("FAIL single_done got done=%b busy=%b want 1/0", b1.done, b1.busy);
    end
    tick();
    tests++;
    if (b1.done !== 1'b0 || b1.ks_ready !== 1'b0) begin
      fails++; $display("FAIL single_after got done=%b ks_ready=%b want 0/0", b1.done, b1.ks_ready);
    end
    idle_inputs();
  endtask

  // First keystream bit lands in the MSB
  task automatic test_msb_first();
    do_reset();
    do_start();
    b.pix_out_ready = 1;
    send_bits(8'hB1);
    send_pix(8'h00);
    tests++;
    if (b.pix_out_valid !== 1'b1 || b.pix_out_data !== 8'hB1) begin
      fails++; $display("FAIL msb_first_0 got v=%b d=%h want v=1 d=b1", b.pix_out_valid, b.pix_out_data);
    end
    send_bits(8'h0F);
    send_pix(8'hFF);
    tests++;
    if (b.pix_out_valid !== 1'b1 || b.pix_out_data !== 8'hF0) begin
      fails++; $display("FAIL msb_first_1 got v=%b d=%h want v=1 d=f0", b.pix_out_valid, b.pix_out_data);
    end
    idle_inputs();
  endtask

  // Continuous streams with sink ready pattern 1,0,0,1
  task automatic test_backpressure();
    logic [7:0] keys [4] = '{8'hA7, 8'h3C, 8'h91, 8'h5E};
    logic [7:0] pix  [4] = '{8'h12, 8'h34, 8'hC8, 8'hF0};
    logic [7:0] expd [4] = '{8'hB5, 8'h08, 8'h59, 8'hAE};
    logic [3:0] pat = 4'b1001;
    logic [7:0] kb;
    logic [7:0] prev_data = 8'h00;
    logic       prev_stall = 1'b0;
    logic       ks_hs, in_hs;
    int bi = 0, pi = 0, oi = 0, dn = 0, post = 0;
    do_reset();
    do_start();
    for (int cyc = 0; cyc < 400; cyc++) begin
      kb = keys[(bi < 32) ? bi / 8 : 3];
      b.ks_valid      = 1'b1;
      b.ks_bit        = (bi < 32) ? kb[7 - (bi % 8)] : 1'b1;
      b.pix_in_valid  = (pi < 4);
      b.pix_in_data   = pix[(pi < 4) ? pi : 3];
      b.pix_out_ready = pat[cyc % 4];
      #1;
      if (prev_stall) begin
        tests++;
        if (b.pix_out_valid !== 1'b1 || b.pix_out_data !== prev_data) begin
          fails++; $display("FAIL bp_hold cyc %0d got v=%b d=%h want v=1 d=%h",
                            cyc, b.pix_out_valid, b.pix_out_data, prev_data);
        end
      end
      if (b.pix_out_valid && b.pix_out_ready) begin
        tests++;
        if (oi >= 4 || b.pix_out_data !== expd[(oi < 4) ? oi : 3]) begin
          fails++; $display("FAIL bp_data out %0d got %h want %h", oi, b.pix_out_data,
                            expd[(oi < 4) ? oi : 3]);
        end
        oi++;
      end
      if (b.ks_ready && b.pix_in_ready) begin
        tests++; fails++;
        $display("FAIL bp_excl cyc %0d got ks_ready=1 pix_in_ready=1 want not both", cyc);
      end
      if (b.done) begin
        dn++;
        tests++;
        if (b.busy !== 1'b0) begin fails++; $display("FAIL bp_busy_done got %b want 0", b.busy); end
      end
      ks_hs      = b.ks_valid && b.ks_ready;
      in_hs      = b.pix_in_valid && b.pix_in_ready;
      prev_stall = b.pix_out_valid && !b.pix_out_ready;
      prev_data  = b.pix_out_data;
      if (dn > 0) post++;
      if (post >= 4) break;
      @(posedge clk); #1;
      if (ks_hs) bi++;
      if (in_hs) pi++;
    end
    tests++;
    if (oi !== 4 || pi !== 4 || dn !== 1) begin
      fails++; $display("FAIL bp_counts got out=%0d in=%0d done=%0d want 4/4/1", oi, pi, dn);
    end
    tests++;
    if (bi !== 32) begin fails++; $display("FAIL bp_ks_bits got %0d want 32", bi); end
    tests++;
    if (b.busy !== 1'b0) begin fails++; $display("FAIL bp_busy_end got %b want 0", b.busy); end
    idle_inputs();
  endtask

  // ks_valid low for 3 cycles after 5 bits: position held, no garbage taken
  task automatic test_ks_stall();
    do_reset();
    do_start();
    b.pix_out_ready = 1;
    feed_bit(1); feed_bit(1); feed_bit(0); feed_bit(0); feed_bit(0);
    b.ks_valid = 0;
    for (int i = 0; i < 3; i++) begin
      b.ks_bit = (i % 2 == 0);
      #1;
      tests++;
      if (u_dut.u_packer.bit_cnt !== 3'd5 || b.ks_ready !== 1'b1) begin
        fails++; $display("FAIL stall_hold got bit_cnt=%0d ks_ready=%b want 5/1",
                          u_dut.u_packer.bit_cnt, b.ks_ready);
      end
      tick();
    end
    feed_bit(1); feed_bit(1); feed_bit(0);
    send_pix(8'h00);
    tests++;
    if (b.pix_out_data !== 8'hC6) begin
      fails++; $display("FAIL stall_byte got %h want c6", b.pix_out_data);
    end
    idle_inputs();
  endtask

  // Reset with 2 pixels sent, one output pending and 3 bits packed
  task automatic test_reset_midimage();
    logic [7:0] keys [4] = '{8'h81, 8'h42, 8'h24, 8'h18};
    logic [7:0] expd [4] = '{8'h7E, 8'hBD, 8'hDB, 8'hE7};
    logic [12:0] o;
    do_reset();
    do_start();
    b.pix_out_ready = 1;
    send_bits(8'h11); send_pix(8'h00);
    send_bits(8'h22);
    b.pix_out_ready = 0;
    send_pix(8'h00);
    feed_bit(1); feed_bit(0); feed_bit(1);
    reset = 1'b1;
    b.start = 1; b.ks_valid = 1; b.pix_in_valid = 1;
    tick();
    o = {b.pix_out_data, b.pix_out_valid, b.busy, b.done, b.ks_ready, b.pix_in_ready};
    tests++;
    if (o !== 13'd0) begin fails++; $display("FAIL mid_reset_out got %h want 0", o); end
    tests++;
    if (u_dut.u_packer.bit_cnt !== 3'd0 || u_dut.pix_cnt !== 3'd0) begin
      fails++; $display("FAIL mid_reset_cnt got bit=%0d pix=%0d want 0/0",
                        u_dut.u_packer.bit_cnt, u_dut.pix_cnt);
    end
    idle_inputs();
    reset = 1'b0;
    tick();
    do_start();
    b.pix_out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      send_bits(keys[k]);
      send_pix(8'hFF);
      tests++;
      if (b.pix_out_data !== expd[k]) begin
        fails++; $display("FAIL mid_reset_img pix %0d got %h want %h", k, b.pix_out_data, expd[k]);
      end
    end
    tick();
    tests++;
    if (b.done !== 1'b1) begin fails++; $display("FAIL mid_reset_done got %b want 1", b.done); end
    tick();
    idle_inputs();
  endtask

  // start during RUN and during DONE has no effect
  task automatic test_start_ignored();
    int dn = 0;
    do_reset();
    do_start();
    b.pix_out_ready = 1;
    send_bits(8'h55); send_pix(8'h0F);
    tests++;
    if (b.pix_out_data !== 8'h5A) begin
      fails++; $display("FAIL start_ign_data got %h want 5a", b.pix_out_data);
    end
    b.start = 1;
    tick();
    b.start = 0;
    tests++;
    if (u_dut.pix_cnt !== 3'd1 || b.busy !== 1'b1) begin
      fails++; $display("FAIL start_in_run got pix_cnt=%0d busy=%b want 1/1", u_dut.pix_cnt, b.busy);
    end
    for (int k = 1; k < 4; k++) begin send_bits(8'h55); send_pix(8'h0F); end
    tick();
    tests++;
    if (b.done !== 1'b1) begin fails++; $display("FAIL start_ign_done got %b want 1", b.done); end
    b.start = 1;
    tick();
    b.start = 0;
    tests++;
    if (b.busy !== 1'b0 || b.ks_ready !== 1'b0 || b.done !== 1'b0) begin
      fails++; $display("FAIL start_in_done got busy=%b ks_ready=%b done=%b want 0/0/0",
                        b.busy, b.ks_ready, b.done);
    end
    for (int i = 0; i < 6; i++) begin
      if (b.done) dn++;
      tick();
    end
    tests++;
    if (dn !== 0) begin fails++; $display("FAIL start_ign_extra_done got %0d want 0", dn); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_pixel();
    test_msb_first();
    test_backpressure();
    test_ks_stall();
    test_reset_midimage();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
